// File: rtl/pkt_fmt_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pkt_fmt_pkg
// Description : Packet word format shared by the ingress buffer: tag
//               encodings, bit-field positions of the 134-bit word and the
//               write-side state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package pkt_fmt_pkg;

  // Two-bit framing tag carried in the top of every packet word
  localparam logic [1:0] TAG_BODY   = 2'b00;
  localparam logic [1:0] TAG_HEAD   = 2'b01;
  localparam logic [1:0] TAG_TAIL   = 2'b10;
  localparam logic [1:0] TAG_SINGLE = 2'b11;

  // Field positions inside a packet word
  localparam int TAG_MSB  = 133;
  localparam int TAG_LSB  = 132;
  localparam int VBC_MSB  = 131;
  localparam int VBC_LSB  = 128;
  localparam int DATA_MSB = 127;
  localparam int DATA_LSB = 0;

  // Write-side packet admission states
  typedef enum logic [1:0] {
    WR_IDLE  = 2'd0,
    WR_WRITE = 2'd1,
    WR_DROP  = 2'd2
  } wr_state_t;

  // A word opens a packet when it is a head or a single-word packet
  function automatic logic tag_is_head(input logic [1:0] tag);
    return (tag == TAG_HEAD) || (tag == TAG_SINGLE);
  endfunction

  // A word closes a packet when it is a tail or a single-word packet
  function automatic logic tag_is_tail(input logic [1:0] tag);
    return (tag == TAG_TAIL) || (tag == TAG_SINGLE);
  endfunction

endpackage
`default_nettype wire

// File: rtl/sdp_ram.sv
`default_nettype none
// ============================================================================
// Module      : sdp_ram
// Description : Simple dual-port memory, one write port and one read port,
//               with a registered read (data valid the cycle after i_re).
//               No reset on the array or read register so it maps to
//               block RAM.
// Revision    : 1.0 - initial release
// ============================================================================
module sdp_ram #(
  parameter int DATA_W = 134,
  parameter int ADDR_W = 8
) (
  input  logic              i_clk,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic              i_re,
  input  logic [ADDR_W-1:0] i_raddr,
  output logic [DATA_W-1:0] o_rdata
);

  logic [DATA_W-1:0] r_mem [0:(2**ADDR_W)-1];
  logic [DATA_W-1:0] r_rdata;

  // Write port
  always_ff @(posedge i_clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  // Registered read port; holds its value while i_re is low
  always_ff @(posedge i_clk) begin
    if (i_re) begin
      r_rdata <= r_mem[i_raddr];
    end
  end

  assign o_rdata = r_rdata;

endmodule
`default_nettype wire

// File: rtl/pkt_ingress_fifo.sv
`default_nettype none
// ============================================================================
// Module      : pkt_ingress_fifo
// Description : Store-and-forward ingress buffer. Admits whole packets from
//               a non-stallable word stream into a circular buffer, commits
//               them only on a clean tail, and replays committed words over
//               a valid/ready handshake through a 2-entry output skid.
// Revision    : 1.0 - initial release
// ============================================================================
module pkt_ingress_fifo
  import pkt_fmt_pkg::*;
#(
  parameter int DATA_W        = 134,
  parameter int ADDR_W        = 8,
  parameter int MAX_PKT_WORDS = 96
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_data_valid,
  input  logic [DATA_W-1:0] i_data,
  output logic              o_data_valid,
  output logic [DATA_W-1:0] o_data,
  input  logic              i_ready,
  output logic [15:0]       o_pkt_cnt,
  output logic [15:0]       o_drop_cnt,
  output logic [15:0]       o_err_cnt
);

  localparam int PTR_W  = ADDR_W + 1;
  localparam int WCNT_W = $clog2(MAX_PKT_WORDS + 1);

  localparam logic [PTR_W-1:0]  c_depth     = PTR_W'(2**ADDR_W);
  localparam logic [PTR_W-1:0]  c_max_pkt   = PTR_W'(MAX_PKT_WORDS);
  localparam logic [PTR_W-1:0]  c_ptr_one   = PTR_W'(1);
  localparam logic [WCNT_W-1:0] c_wcnt_one  = WCNT_W'(1);
  // Word count at which a further non-tail word makes the packet oversize
  localparam logic [WCNT_W-1:0] c_last_body = WCNT_W'(MAX_PKT_WORDS - 1);
  localparam logic [15:0]       c_cnt_one   = 16'd1;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  wr_state_t          r_state;
  logic [PTR_W-1:0]   r_wr_ptr;
  logic [PTR_W-1:0]   r_commit_ptr;
  logic [PTR_W-1:0]   r_rd_ptr;
  logic [WCNT_W-1:0]  r_wcnt;
  logic [15:0]        r_pkt_cnt;
  logic [15:0]        r_drop_cnt;
  logic [15:0]        r_err_cnt;

  // Output queue: r_sk_* is the older entry, the RAM read register the newer
  logic               r_sk_valid;
  logic [DATA_W-1:0]  r_sk_data;
  logic               r_rq_valid;

  // ---------------------------------------------------------------------------
  // Combinational decode
  // ---------------------------------------------------------------------------
  logic [1:0]         w_tag;
  logic               w_head;
  logic               w_tail;
  logic [PTR_W-1:0]   w_used;
  logic [PTR_W-1:0]   w_free;
  logic               w_admit;
  logic               w_we;
  logic [ADDR_W-1:0]  w_waddr;
  logic [DATA_W-1:0]  w_ram_q;
  logic               w_pop;
  logic               w_sk_left;
  logic               w_rq_left;
  logic               w_re;

  // Admission and RAM write decode for the incoming word. Space is measured
  // from commit_ptr so a head arriving mid-packet sees the rolled-back view.
  always_comb begin
    w_tag   = i_data[TAG_MSB:TAG_LSB];
    w_head  = tag_is_head(w_tag);
    w_tail  = tag_is_tail(w_tag);
    w_used  = r_commit_ptr - r_rd_ptr;
    w_free  = c_depth - w_used;
    w_admit = (w_free >= c_max_pkt);
    w_we    = 1'b0;
    w_waddr = r_wr_ptr[ADDR_W-1:0];
    if (i_data_valid) begin
      if (w_head) begin
        w_we    = w_admit;
        w_waddr = r_commit_ptr[ADDR_W-1:0];
      end else if (r_state == WR_WRITE) begin
        // The word that would make the packet oversize is not stored
        w_we = w_tail || (r_wcnt != c_last_body);
      end
    end
  end

  // Read-side queue bookkeeping: what survives this cycle's pop, and whether
  // a new RAM read fits behind it
  always_comb begin
    w_pop     = o_data_valid && i_ready;
    w_sk_left = r_sk_valid && !w_pop;
    w_rq_left = r_rq_valid && !(w_pop && !r_sk_valid);
    w_re      = (r_rd_ptr != r_commit_ptr) && !(w_sk_left && w_rq_left);
  end

  // ---------------------------------------------------------------------------
  // Packet buffer
  // ---------------------------------------------------------------------------
  sdp_ram #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .i_clk   (i_clk),
    .i_we    (w_we),
    .i_waddr (w_waddr),
    .i_wdata (i_data),
    .i_re    (w_re),
    .i_raddr (r_rd_ptr[ADDR_W-1:0]),
    .o_rdata (w_ram_q)
  );

  // Write FSM: admit, store, commit, roll back or drop whole packets
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state      <= WR_IDLE;
      r_wr_ptr     <= '0;
      r_commit_ptr <= '0;
      r_wcnt       <= '0;
      r_pkt_cnt    <= '0;
      r_drop_cnt   <= '0;
      r_err_cnt    <= '0;
    end else if (i_data_valid) begin
      if (w_head) begin
        // A head while a packet is open means the previous tail went missing
        if (r_state == WR_WRITE) begin
          r_err_cnt <= r_err_cnt + c_cnt_one;
        end
        if (w_admit) begin
          r_wr_ptr <= r_commit_ptr + c_ptr_one;
          if (w_tail) begin
            r_commit_ptr <= r_commit_ptr + c_ptr_one;
            r_pkt_cnt    <= r_pkt_cnt + c_cnt_one;
            r_state      <= WR_IDLE;
          end else begin
            r_wcnt  <= c_wcnt_one;
            r_state <= WR_WRITE;
          end
        end else begin
          r_wr_ptr   <= r_commit_ptr;
          r_drop_cnt <= r_drop_cnt + c_cnt_one;
          r_state    <= w_tail ? WR_IDLE : WR_DROP;
        end
      end else begin
        case (r_state)
          WR_IDLE: begin
            r_err_cnt <= r_err_cnt + c_cnt_one;
          end
          WR_WRITE: begin
            if (w_tail) begin
              r_wr_ptr     <= r_wr_ptr + c_ptr_one;
              r_commit_ptr <= r_wr_ptr + c_ptr_one;
              r_pkt_cnt    <= r_pkt_cnt + c_cnt_one;
              r_state      <= WR_IDLE;
            end else if (r_wcnt == c_last_body) begin
              r_wr_ptr  <= r_commit_ptr;
              r_err_cnt <= r_err_cnt + c_cnt_one;
              r_state   <= WR_DROP;
            end else begin
              r_wr_ptr <= r_wr_ptr + c_ptr_one;
              r_wcnt   <= r_wcnt + c_wcnt_one;
            end
          end
          WR_DROP: begin
            if (w_tail) begin
              r_state <= WR_IDLE;
            end
          end
          default: begin
            r_state <= WR_IDLE;
          end
        endcase
      end
    end
  end

  // Read side: fetch committed words into the RAM read register and shift
  // an unconsumed word into the skid whenever a newer read overwrites it
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_rd_ptr   <= '0;
      r_sk_valid <= 1'b0;
      r_sk_data  <= '0;
      r_rq_valid <= 1'b0;
    end else if (w_re) begin
      r_rd_ptr   <= r_rd_ptr + c_ptr_one;
      r_rq_valid <= 1'b1;
      if (w_rq_left) begin
        r_sk_data  <= w_ram_q;
        r_sk_valid <= 1'b1;
      end else begin
        r_sk_valid <= w_sk_left;
      end
    end else begin
      r_rq_valid <= w_rq_left;
      r_sk_valid <= w_sk_left;
    end
  end

  // Oldest queued word is presented; zero when nothing is queued
  assign o_data_valid = r_sk_valid || r_rq_valid;
  assign o_data       = r_sk_valid ? r_sk_data : (r_rq_valid ? w_ram_q : '0);
  assign o_pkt_cnt    = r_pkt_cnt;
  assign o_drop_cnt   = r_drop_cnt;
  assign o_err_cnt    = r_err_cnt;

endmodule
`default_nettype wire
